// File: rtl/rvj1_lsu_nb_pkg.sv
// Shared LSU types: command encoding, bus geometry and the in-flight tracking record.
package rvj1_defines;

  localparam int XLEN   = 32;
  localparam int RALEN  = 5;
  localparam int NBYTES = XLEN / 8;

  // bit3 = write, bit2 = unsigned load, bit1 = word, bit0 = half
  typedef enum logic [3:0] {
    LSU_LB  = 4'b0000,
    LSU_LH  = 4'b0001,
    LSU_LW  = 4'b0010,
    LSU_LBU = 4'b0100,
    LSU_LHU = 4'b0101,
    LSU_SB  = 4'b1000,
    LSU_SH  = 4'b1001,
    LSU_SW  = 4'b1010
  } lsu_ctrl_e;

  typedef struct packed {
    logic [3:0]       cmd;
    logic [XLEN-1:0]  addr;
    logic [RALEN-1:0] regdest;
  } lsu_track_t;

endpackage

// File: rtl/rvj1_lsu_nb_track_fifo.sv
// In-order tracking FIFO for issued bus requests awaiting their response.
module rvj1_lsu_track_fifo
  import rvj1_defines::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  lsu_track_t    din_i,
  input  logic          pop_i,
  output lsu_track_t    dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  lsu_track_t        mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     cnt;

  function automatic logic [AW-1:0] ptr_inc(logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_i) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_i)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_i, pop_i})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign dout_o  = mem[rd_ptr];
  assign full_o  = (cnt == CW'(DEPTH));
  assign empty_o = (cnt == '0);
  assign count_o = cnt;

endmodule

// File: rtl/rvj1_lsu_nb.sv
// Non-blocking load-store unit: one issue slot, in-order response tracking,
// misalignment and bus-error reporting.
module rvj1_lsu_nb
  import rvj1_defines::*;
#(
  parameter int MAX_OUTST  = 4,
  parameter bit LOAD_BLOCK = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              lsu_valid_i,
  output logic              lsu_ready_o,
  input  logic [3:0]        lsu_cmd_i,
  input  logic [XLEN-1:0]   lsu_addr_i,
  input  logic [XLEN-1:0]   lsu_data_i,
  input  logic [RALEN-1:0]  lsu_regdest_i,
  output logic [XLEN-1:0]   rf_data_o,
  output logic              rf_wb_o,
  output logic [RALEN-1:0]  rf_dest_o,
  output logic              ctrl_misaligned_load_o,
  output logic              ctrl_misaligned_store_o,
  output logic              ctrl_bus_error_o,
  output logic [XLEN-1:0]   ctrl_exception_addr_o,
  output logic [XLEN-1:0]   data_req_addr_o,
  output logic [XLEN-1:0]   data_req_data_o,
  output logic [NBYTES-1:0] data_req_strobe_o,
  output logic              data_req_write_o,
  output logic              data_req_valid_o,
  input  logic              data_req_ready_i,
  input  logic [XLEN-1:0]   data_rsp_data_i,
  input  logic              data_rsp_error_i,
  input  logic              data_rsp_valid_i,
  output logic              data_rsp_ready_o
);

  localparam int CW = $clog2(MAX_OUTST + 1);

  typedef enum logic {RUN, LWAIT} state_e;

  function automatic logic [NBYTES-1:0] lane_strb(logic [3:0] cmd, logic [1:0] a);
    if (cmd[1]) return '1;
    if (cmd[0]) return NBYTES'(4'b0011) << a;
    return NBYTES'(4'b0001) << a;
  endfunction

  function automatic logic [XLEN-1:0] load_ext(logic [XLEN-1:0] d, logic [3:0] cmd,
                                               logic [1:0] a);
    logic [XLEN-1:0] s;
    s = d >> {a, 3'b000};
    if (cmd[1]) return s;
    if (cmd[0]) return cmd[2] ? {16'b0, s[15:0]} : {{16{s[15]}}, s[15:0]};
    return cmd[2] ? {24'b0, s[7:0]} : {{24{s[7]}}, s[7:0]};
  endfunction

  state_e            state_q, state_d;
  logic              slot_vld;
  lsu_track_t        slot;
  logic [XLEN-1:0]   slot_data;
  logic [NBYTES-1:0] slot_strb;
  lsu_track_t        head;
  logic              trk_full, trk_empty;
  logic [CW-1:0]     trk_cnt;
  logic              misaligned, accept, acc_ok, req_fire, rsp_fire, rsp_load_ok;

  assign misaligned = lsu_cmd_i[1] ? (lsu_addr_i[1:0] != 2'b00) : (lsu_cmd_i[0] & lsu_addr_i[0]);
  assign req_fire   = slot_vld & data_req_ready_i;

  // The slot counts against the outstanding budget so the FIFO can never overflow.
  assign lsu_ready_o = !rst_i && (state_q == RUN) && (!slot_vld || req_fire) && !trk_full &&
                       ((int'(trk_cnt) + int'(slot_vld)) < MAX_OUTST);
  assign accept      = lsu_valid_i & lsu_ready_o;
  assign acc_ok      = accept & ~misaligned;

  assign data_rsp_ready_o = !rst_i && !trk_empty;
  assign rsp_fire         = data_rsp_valid_i & data_rsp_ready_o;
  assign rsp_load_ok      = rsp_fire & ~head.cmd[3] & ~data_rsp_error_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_vld  <= 1'b0;
      slot      <= '0;
      slot_data <= '0;
      slot_strb <= '0;
    end else if (acc_ok) begin
      slot_vld  <= 1'b1;
      slot      <= '{cmd: lsu_cmd_i, addr: lsu_addr_i, regdest: lsu_regdest_i};
      slot_data <= lsu_data_i << {lsu_addr_i[1:0], 3'b000};
      slot_strb <= lane_strb(lsu_cmd_i, lsu_addr_i[1:0]);
    end else if (req_fire) begin
      slot_vld <= 1'b0;
    end
  end

  assign data_req_valid_o  = slot_vld;
  assign data_req_addr_o   = {slot.addr[XLEN-1:2], 2'b00};
  assign data_req_data_o   = slot_data;
  assign data_req_strobe_o = slot_strb;
  assign data_req_write_o  = slot.cmd[3];

  rvj1_lsu_track_fifo #(.DEPTH(MAX_OUTST)) u_track (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (req_fire),
    .din_i   (slot),
    .pop_i   (rsp_fire),
    .dout_o  (head),
    .full_o  (trk_full),
    .empty_o (trk_empty),
    .count_o (trk_cnt)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= RUN;
    else       state_q <= state_d;
  end

  // While blocked, the only load that can be tracked is the one that blocked us.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (LOAD_BLOCK && acc_ok && !lsu_cmd_i[3]) state_d = LWAIT;
      LWAIT:   if (rsp_fire && !head.cmd[3])              state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rf_wb_o                 <= 1'b0;
      rf_data_o               <= '0;
      rf_dest_o               <= '0;
      ctrl_misaligned_load_o  <= 1'b0;
      ctrl_misaligned_store_o <= 1'b0;
      ctrl_bus_error_o        <= 1'b0;
      ctrl_exception_addr_o   <= '0;
    end else begin
      rf_wb_o <= rsp_load_ok;
      if (rsp_load_ok) begin
        rf_data_o <= load_ext(data_rsp_data_i, head.cmd, head.addr[1:0]);
        rf_dest_o <= head.regdest;
      end
      ctrl_misaligned_load_o  <= accept & misaligned & ~lsu_cmd_i[3];
      ctrl_misaligned_store_o <= accept & misaligned &  lsu_cmd_i[3];
      ctrl_bus_error_o        <= rsp_fire & data_rsp_error_i;
      if (rsp_fire && data_rsp_error_i) ctrl_exception_addr_o <= head.addr;
      else if (accept && misaligned)    ctrl_exception_addr_o <= lsu_addr_i;
    end
  end

endmodule
